// File: rtl/rf_wb_arb.sv
// rf_wb_arb: two-source (ALU, LD) writeback arbiter and sequencer for the 32x32 register file.
// Define RR_ARB_EN for round-robin arbitration; the default build uses fixed LD-over-ALU priority.

// Simulation-only checks of the upstream write-hazard guarantees.
module rf_wb_arb_chk #(
    parameter int AW = 5,
    parameter int NS = 32
) (
    input logic          CLK,
    input logic          RESET,
    input logic [1:0]    push_i,
    input logic [AW-1:0] alu_addr_i,
    input logic [AW-1:0] ld_addr_i,
    input logic [NS-1:0] busy_i
);
    a_alu_not_busy: assert property (@(posedge CLK) disable iff (RESET) push_i[0] |-> !busy_i[alu_addr_i]);
    a_ld_not_busy:  assert property (@(posedge CLK) disable iff (RESET) push_i[1] |-> !busy_i[ld_addr_i]);
    a_distinct:     assert property (@(posedge CLK) disable iff (RESET) (&push_i) |-> (alu_addr_i != ld_addr_i));
endmodule

module rf_wb_arb #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ALU_VALID,
    output logic             ALU_READY,
    input  logic [AW-1:0]    ALU_ADDR,
    input  logic [DW-1:0]    ALU_DATA,
    input  logic             LD_VALID,
    output logic             LD_READY,
    input  logic [AW-1:0]    LD_ADDR,
    input  logic [DW-1:0]    LD_DATA,
    output logic [AW-1:0]    RDaddr,
    output logic [DW-1:0]    RD,
    output logic [2**AW-1:0] BUSY
);
    localparam int PW      = $clog2(DEPTH) + 1;
    localparam int IW      = PW - 1;
    localparam int NS      = 2**AW;
    localparam int SRC_ALU = 0;
    localparam int SRC_LD  = 1;
    localparam logic [NS-1:0] BIT0 = {{(NS-1){1'b0}}, 1'b1};

    logic [AW-1:0] addr_mem_q [2][DEPTH];
    logic [DW-1:0] data_mem_q [2][DEPTH];
    logic [PW-1:0] wr_ptr_q [2];
    logic [PW-1:0] wr_ptr_d [2];
    logic [PW-1:0] rd_ptr_q [2];
    logic [PW-1:0] rd_ptr_d [2];
    logic [AW-1:0] in_addr_s [2];
    logic [DW-1:0] in_data_s [2];
    logic [AW-1:0] rdaddr_q, rdaddr_d;
    logic [DW-1:0] rd_q, rd_d;
    logic [NS-1:0] busy_q, busy_d, set_mask_s, clr_mask_s;
    logic [1:0]    valid_s, full_s, nonempty_s, ready_s, push_s, pop_s;
    logic          grant_ld_s, contended_s;
`ifdef RR_ARB_EN
    logic          last_alu_q, last_alu_d;
`endif

    // Per-source FIFO status, READY and accept qualification (address 0 is dropped).
    always_comb begin
        in_addr_s[SRC_ALU] = ALU_ADDR;
        in_addr_s[SRC_LD]  = LD_ADDR;
        in_data_s[SRC_ALU] = ALU_DATA;
        in_data_s[SRC_LD]  = LD_DATA;
        valid_s    = {LD_VALID, ALU_VALID};
        nonempty_s = 2'b00;
        full_s     = 2'b00;
        ready_s    = 2'b00;
        push_s     = 2'b00;
        for (int s = 0; s < 2; s++) begin
            nonempty_s[s] = (wr_ptr_q[s] != rd_ptr_q[s]);
            full_s[s]     = (wr_ptr_q[s][PW-1] != rd_ptr_q[s][PW-1]) &&
                            (wr_ptr_q[s][IW-1:0] == rd_ptr_q[s][IW-1:0]);
            ready_s[s]    = !RESET && !full_s[s];
            push_s[s]     = valid_s[s] && ready_s[s] && (in_addr_s[s] != {AW{1'b0}});
        end
    end

    // Grant selection between the two FIFO heads.
    always_comb begin
        contended_s = &nonempty_s;
        grant_ld_s  = 1'b0;
`ifdef RR_ARB_EN
        last_alu_d  = last_alu_q;
`endif
        if (contended_s) begin
`ifdef RR_ARB_EN
            grant_ld_s = last_alu_q;
            last_alu_d = !last_alu_q;
`else
            grant_ld_s = 1'b1;
`endif
        end else begin
            grant_ld_s = nonempty_s[SRC_LD];
        end
        pop_s = {grant_ld_s && nonempty_s[SRC_LD], !grant_ld_s && nonempty_s[SRC_ALU]};
    end

    // Pointer advance, output-stage load and pending-write vector update.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            wr_ptr_d[s] = wr_ptr_q[s] + {{(PW-1){1'b0}}, push_s[s]};
            rd_ptr_d[s] = rd_ptr_q[s] + {{(PW-1){1'b0}}, pop_s[s]};
        end
        rdaddr_d = {AW{1'b0}};
        rd_d     = {DW{1'b0}};
        if (pop_s[SRC_LD]) begin
            rdaddr_d = addr_mem_q[SRC_LD][rd_ptr_q[SRC_LD][IW-1:0]];
            rd_d     = data_mem_q[SRC_LD][rd_ptr_q[SRC_LD][IW-1:0]];
        end else if (pop_s[SRC_ALU]) begin
            rdaddr_d = addr_mem_q[SRC_ALU][rd_ptr_q[SRC_ALU][IW-1:0]];
            rd_d     = data_mem_q[SRC_ALU][rd_ptr_q[SRC_ALU][IW-1:0]];
        end else begin
            rdaddr_d = {AW{1'b0}};
            rd_d     = {DW{1'b0}};
        end
        // The output register is replaced every edge, so its register is retired now.
        clr_mask_s = BIT0 << rdaddr_q;
        set_mask_s = (push_s[SRC_ALU] ? (BIT0 << in_addr_s[SRC_ALU]) : {NS{1'b0}}) |
                     (push_s[SRC_LD]  ? (BIT0 << in_addr_s[SRC_LD])  : {NS{1'b0}});
        busy_d = (busy_q & ~clr_mask_s) | set_mask_s;
    end

    // Control state, output stage and pending-write vector.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int s = 0; s < 2; s++) begin
                wr_ptr_q[s] <= {PW{1'b0}};
                rd_ptr_q[s] <= {PW{1'b0}};
            end
            rdaddr_q <= {AW{1'b0}};
            rd_q     <= {DW{1'b0}};
            busy_q   <= {NS{1'b0}};
        end else begin
            for (int s = 0; s < 2; s++) begin
                wr_ptr_q[s] <= wr_ptr_d[s];
                rd_ptr_q[s] <= rd_ptr_d[s];
            end
            rdaddr_q <= rdaddr_d;
            rd_q     <= rd_d;
            busy_q   <= busy_d;
        end
    end

`ifdef RR_ARB_EN
    // Last contended winner; starts as ALU so LD wins the first contention.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            last_alu_q <= 1'b1;
        end else begin
            last_alu_q <= last_alu_d;
        end
    end
`endif

    // FIFO storage; contents need no reset because the pointers gate visibility.
    always_ff @(posedge CLK) begin
        for (int s = 0; s < 2; s++) begin
            if (push_s[s]) begin
                addr_mem_q[s][wr_ptr_q[s][IW-1:0]] <= in_addr_s[s];
                data_mem_q[s][wr_ptr_q[s][IW-1:0]] <= in_data_s[s];
            end
        end
    end

    assign ALU_READY = ready_s[SRC_ALU];
    assign LD_READY  = ready_s[SRC_LD];
    assign RDaddr    = rdaddr_q;
    assign RD        = rd_q;
    assign BUSY      = busy_q;

    rf_wb_arb_chk #(.AW(AW), .NS(NS)) u_chk (
        .CLK        (CLK),
        .RESET      (RESET),
        .push_i     (push_s),
        .alu_addr_i (ALU_ADDR),
        .ld_addr_i  (LD_ADDR),
        .busy_i     (busy_q)
    );
endmodule

// File: tb/tb_rf_wb_arb.sv
// Scoreboard bench for rf_wb_arb: a queue-based reference model predicts issue order,
// READY and BUSY; a separate monitor compares the write port every cycle.
module tb_rf_wb_arb;
    localparam int DEPTH = 2;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        ALU_VALID, ALU_READY, LD_VALID, LD_READY;
    logic [4:0]  ALU_ADDR, LD_ADDR, RDaddr;
    logic [31:0] ALU_DATA, LD_DATA, RD, BUSY;

    rf_wb_arb #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
        .CLK(CLK), .RESET(RESET),
        .ALU_VALID(ALU_VALID), .ALU_READY(ALU_READY), .ALU_ADDR(ALU_ADDR), .ALU_DATA(ALU_DATA),
        .LD_VALID(LD_VALID), .LD_READY(LD_READY), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA),
        .RDaddr(RDaddr), .RD(RD), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
    typedef struct { logic [4:0] a; logic [31:0] d; int cyc; } exp_t;

    wr_t        alu_m[$];
    wr_t        ld_m[$];
    exp_t       sb[$];
    int         cyc = 0;
    logic [4:0] m_out = 5'd0;
    bit         last_ld = 1'b0;
    bit         m_acc_alu = 1'b0;
    int         n_vec = 0;
    int         n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Pending writes: everything queued in either FIFO plus the write on the port.
    function automatic logic [31:0] model_busy();
        logic [31:0] b;
        b = 32'd0;
        foreach (alu_m[i]) b[alu_m[i].a] = 1'b1;
        foreach (ld_m[i])  b[ld_m[i].a]  = 1'b1;
        b[m_out] = 1'b1;
        b[0] = 1'b0;
        return b;
    endfunction

    task automatic check_state();
        chk("alu_ready", {63'd0, ALU_READY}, {63'd0, alu_m.size() < DEPTH});
        chk("ld_ready",  {63'd0, LD_READY},  {63'd0, ld_m.size() < DEPTH});
        chk("busy",      {32'd0, BUSY},      {32'd0, model_busy()});
    endtask

    task automatic model_edge();
        bit  acc_a, acc_l, take_ld, popped;
        wr_t w;
        acc_a = ALU_VALID && (alu_m.size() < DEPTH) && (ALU_ADDR != 5'd0);
        acc_l = LD_VALID && (ld_m.size() < DEPTH) && (LD_ADDR != 5'd0);
        m_acc_alu = acc_a;
        cyc++;
        popped = 1'b0;
        if (ld_m.size() > 0 && alu_m.size() > 0) begin
`ifdef RR_ARB_EN
            take_ld = !last_ld;
            last_ld = take_ld;
`else
            take_ld = 1'b1;
`endif
        end else begin
            take_ld = (ld_m.size() > 0);
        end
        if (take_ld) begin
            w = ld_m.pop_front();
            popped = 1'b1;
        end else if (alu_m.size() > 0) begin
            w = alu_m.pop_front();
            popped = 1'b1;
        end
        m_out = 5'd0;
        if (popped) begin
            sb.push_back('{w.a, w.d, cyc});
            m_out = w.a;
        end
        if (acc_a) alu_m.push_back('{ALU_ADDR, ALU_DATA});
        if (acc_l) ld_m.push_back('{LD_ADDR, LD_DATA});
    endtask

    task automatic step(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                        input bit lv, input logic [4:0] la, input logic [31:0] ld);
        @(negedge CLK);
        check_state();
        ALU_VALID = av; ALU_ADDR = aa; ALU_DATA = ad;
        LD_VALID  = lv; LD_ADDR  = la; LD_DATA  = ld;
        @(posedge CLK);
        model_edge();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic rand_step();
        logic [31:0] b;
        logic [4:0]  aa, la;
        bit          av, lv;
        b  = model_busy();
        aa = 5'($urandom_range(0, 31));
        la = 5'($urandom_range(0, 31));
        av = ($urandom_range(0, 3) != 0) && !b[aa];
        lv = ($urandom_range(0, 3) != 0) && !b[la] && ((la != aa) || (la == 5'd0));
        step(av, aa, $urandom, lv, la, $urandom);
    endtask

    // Monitor: the write port must show the predicted write on its cycle, else idle.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                chk("issue_addr", {59'd0, RDaddr}, {59'd0, e.a});
                chk("issue_data", {32'd0, RD}, {32'd0, e.d});
            end else begin
                chk("idle_addr", {59'd0, RDaddr}, 64'd0);
            end
        end
    end

    initial begin
        int ai;
        RESET = 1'b1;
        ALU_VALID = 1'b0; ALU_ADDR = 5'd0; ALU_DATA = 32'd0;
        LD_VALID  = 1'b0; LD_ADDR  = 5'd0; LD_DATA  = 32'd0;
        #12;
        chk("rst_rdaddr", {59'd0, RDaddr}, 64'd0);
        chk("rst_rd", {32'd0, RD}, 64'd0);
        chk("rst_busy", {32'd0, BUSY}, 64'd0);
        chk("rst_alu_ready", {63'd0, ALU_READY}, 64'd0);
        chk("rst_ld_ready", {63'd0, LD_READY}, 64'd0);
        @(negedge CLK);
        #2 RESET = 1'b0;

        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        idle(4);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234);
        idle(3);
        step(1'b1, 5'd1, 32'd11, 1'b1, 5'd3, 32'd33);
        step(1'b1, 5'd2, 32'd22, 1'b1, 5'd4, 32'd44);
        idle(6);

        ai = 0;
        for (int i = 0; i < 9; i++) begin
            step(ai < 3, 5'(8 + ai), 32'(100 + ai), i < 5, 5'(16 + i), 32'(200 + i));
            if (m_acc_alu) ai++;
        end
        idle(6);

        for (int i = 1; i <= 10; i++) step(1'b1, 5'(i), 32'(i * 3), 1'b0, 5'd0, 32'd0);
        idle(4);

        repeat (400) rand_step();
        idle(8);

        step(1'b1, 5'd20, 32'h20, 1'b1, 5'd21, 32'h21);
        step(1'b1, 5'd22, 32'h22, 1'b0, 5'd0, 32'd0);
        @(negedge CLK);
        ALU_VALID = 1'b0; LD_VALID = 1'b0;
        #2 RESET = 1'b1;
        alu_m.delete(); ld_m.delete(); sb.delete();
        m_out = 5'd0; last_ld = 1'b0;
        #1;
        chk("mid_rst_rdaddr", {59'd0, RDaddr}, 64'd0);
        chk("mid_rst_busy", {32'd0, BUSY}, 64'd0);
        chk("mid_rst_alu_ready", {63'd0, ALU_READY}, 64'd0);
        chk("mid_rst_ld_ready", {63'd0, LD_READY}, 64'd0);
        @(negedge CLK);
        #2 RESET = 1'b0;
        step(1'b1, 5'd7, 32'd7, 1'b0, 5'd0, 32'd0);
        idle(6);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
